riscv_imem_resp: RTL and testbench

Responder side of the instruction-fetch interface. It accepts fetch requests (byte PC) over a valid/ready handshake and returns the addressed 32-bit instruction one cycle later through a registered response slot. It also contains a byte-serial program loader that fills the word array before execution. The fetch stage is its initiator; a boot/debug byte source drives the loader.

---
 rtl/riscv_imem_resp.sv | 141 ++++++++++++++
 tb/tb_riscv_imem_resp.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_imem_resp.sv
// Instruction-memory responder: single-slot fetch response path plus a byte-serial
// program loader that fills the word array before execution.
module riscv_imem_resp #(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     IMEM_ADDR_BIT = 12,
  parameter logic [XLEN-1:0] NOP_INSTR     = 32'h0000_0013
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_req_valid,
  output logic                     o_req_ready,
  input  logic [XLEN-1:0]          i_req_addr,
  output logic                     o_rsp_valid,
  input  logic                     i_rsp_ready,
  output logic [XLEN-1:0]          o_rsp_data,
  output logic                     o_rsp_err,
  input  logic                     i_ld_en,
  input  logic                     i_ld_valid,
  output logic                     o_ld_ready,
  input  logic [7:0]               i_ld_byte,
  output logic [IMEM_ADDR_BIT-2:0] o_ld_words,
  output logic                     o_ld_ovf
);

  localparam int unsigned      PTR_W     = IMEM_ADDR_BIT - 2;
  localparam int unsigned      CNT_W     = IMEM_ADDR_BIT - 1;
  localparam int unsigned      DEPTH     = 1 << PTR_W;
  localparam logic [CNT_W-1:0] WORDS_MAX = CNT_W'(DEPTH);

  typedef enum logic [1:0] {StRun, StLoad, StFlush} state_e;

  state_e            r_state;
  state_e            w_state_next;

  logic [XLEN-1:0]   r_mem [DEPTH];
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [XLEN-1:0]   r_rsp_data;
  logic [1:0]        r_byte_cnt;
  logic [23:0]       r_asm;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_ld_words;
  logic              r_ld_ovf;

  logic              w_slot_free;
  logic              w_req_ready;
  logic              w_ld_ready;
  logic              w_req_fire;
  logic              w_ld_fire;
  logic              w_addr_err;
  logic              w_word_we;
  logic              w_enter_load;
  logic [XLEN-1:0]   w_word;

  assign w_slot_free = !r_rsp_valid || i_rsp_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= StRun;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StRun:   if (i_ld_en && w_slot_free) w_state_next = StLoad;
      StLoad:  if (!i_ld_en) w_state_next = StFlush;
      StFlush: w_state_next = StRun;
      default: w_state_next = StRun;
    endcase
  end

  always_comb begin
    w_req_ready = 1'b0;
    w_ld_ready  = 1'b0;
    unique case (r_state)
      StRun:   w_req_ready = w_slot_free && !i_ld_en;
      StLoad:  w_ld_ready  = i_ld_en;
      default: ;
    endcase
  end

  assign w_enter_load = (r_state == StRun) && (w_state_next == StLoad);
  assign w_req_fire   = i_req_valid && w_req_ready;
  assign w_ld_fire    = i_ld_valid && w_ld_ready;
  assign w_addr_err   = (i_req_addr[1:0] != 2'b00) || (|i_req_addr[XLEN-1:IMEM_ADDR_BIT]);

  // Full word on the fourth byte, or a zero-padded partial word during the flush cycle.
  assign w_word_we = (w_ld_fire && r_byte_cnt == 2'd3) ||
                     (r_state == StFlush && r_byte_cnt != 2'd0);
  assign w_word    = w_ld_fire ? XLEN'({i_ld_byte, r_asm}) : XLEN'({8'h00, r_asm});

  always_ff @(posedge i_clk) begin
    if (!i_rst && w_word_we) r_mem[r_wr_ptr] <= w_word;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_data  <= '0;
    end else if (w_req_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_addr_err;
      r_rsp_data  <= w_addr_err ? NOP_INSTR : r_mem[i_req_addr[IMEM_ADDR_BIT-1:2]];
    end else if (r_rsp_valid && i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || w_enter_load) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= '0;
      r_wr_ptr   <= '0;
      r_ld_words <= '0;
      r_ld_ovf   <= 1'b0;
    end else if (w_word_we) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= '0;
      r_wr_ptr   <= r_wr_ptr + 1'b1;
      if (r_ld_words != WORDS_MAX) r_ld_words <= r_ld_words + 1'b1;
      if (r_wr_ptr == '1) r_ld_ovf <= 1'b1;
    end else if (w_ld_fire) begin
      unique case (r_byte_cnt)
        2'd0:    r_asm[7:0]   <= i_ld_byte;
        2'd1:    r_asm[15:8]  <= i_ld_byte;
        default: r_asm[23:16] <= i_ld_byte;
      endcase
      r_byte_cnt <= r_byte_cnt + 1'b1;
    end
  end

  assign o_req_ready = w_req_ready;
  assign o_ld_ready  = w_ld_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_err   = r_rsp_err;
  assign o_rsp_data  = r_rsp_data;
  assign o_ld_words  = r_ld_words;
  assign o_ld_ovf    = r_ld_ovf;

endmodule

// File: tb/tb_riscv_imem_resp.sv
// Randomized bench for riscv_imem_resp against a slot/word-level reference model.
module tb_riscv_imem_resp;

  localparam int unsigned AB    = 12;
  localparam int unsigned DEPTH = 1 << (AB - 2);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, req_valid, rsp_ready, ld_en, ld_valid;
  logic [31:0]   req_addr;
  logic [7:0]    ld_byte;
  logic          req_ready, rsp_valid, rsp_err, ld_ready, ld_ovf;
  logic [31:0]   rsp_data;
  logic [AB-2:0] ld_words;

  int            total = 0;
  int            bad   = 0;

  logic [31:0]   m_mem [DEPTH];
  bit            m_valid;
  bit            m_err;
  logic [31:0]   m_data;
  int            m_words;
  bit            m_ovf;
  byte unsigned  src_q[$];

  riscv_imem_resp #(
    .XLEN         (32),
    .IMEM_ADDR_BIT(AB),
    .NOP_INSTR    (NOP)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req_valid(req_valid),
    .o_req_ready(req_ready),
    .i_req_addr (req_addr),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_data (rsp_data),
    .o_rsp_err  (rsp_err),
    .i_ld_en    (ld_en),
    .i_ld_valid (ld_valid),
    .o_ld_ready (ld_ready),
    .i_ld_byte  (ld_byte),
    .o_ld_words (ld_words),
    .o_ld_ovf   (ld_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One RUN cycle: drive, compare against the slot model before the edge, then advance it.
  task automatic cyc(input logic v, input logic [31:0] a, input logic rr);
    bit e;
    bit exp_rdy;
    req_valid = v;
    req_addr  = a;
    rsp_ready = rr;
    @(negedge clk);
    exp_rdy = !m_valid || rr;
    check("req_ready", {31'd0, req_ready}, {31'd0, exp_rdy});
    check("ld_ready_run", {31'd0, ld_ready}, 32'd0);
    check("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    if (m_valid) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
    end
    @(posedge clk);
    if (v && exp_rdy) begin
      e       = (a[1:0] != 2'b00) || (a >= 32'(1 << AB));
      m_valid = 1'b1;
      m_err   = e;
      m_data  = e ? NOP : m_mem[a[AB-1:2]];
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  // Enter LOAD, stream src_q with random gaps, drop ld_en, pass FLUSH, then update the model.
  task automatic load_run();
    byte unsigned got[$];
    int           w;
    logic [31:0]  wd;
    ld_en     = 1'b1;
    ld_valid  = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("req_ready_lden", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    m_valid = 1'b0;
    while (src_q.size() > 0) begin
      ld_valid = ($urandom_range(0, 3) != 0);
      ld_byte  = src_q[0];
      @(negedge clk);
      check("ld_ready_load", {31'd0, ld_ready}, 32'd1);
      @(posedge clk);
      #1;
      if (ld_valid) got.push_back(src_q.pop_front());
    end
    ld_en    = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'hFF;
    @(negedge clk);
    check("ld_ready_exit", {31'd0, ld_ready}, 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("ld_ready_flush", {31'd0, ld_ready}, 32'd0);
    check("req_ready_flush", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    w = (got.size() + 3) / 4;
    for (int i = 0; i < w; i++) begin
      wd = 32'd0;
      for (int b = 0; b < 4; b++) begin
        if (4 * i + b < got.size()) wd[8*b +: 8] = got[4*i+b];
      end
      m_mem[i % DEPTH] = wd;
    end
    m_words = (w < DEPTH) ? w : DEPTH;
    m_ovf   = (w >= DEPTH);
    @(negedge clk);
    check("ld_words", {21'd0, ld_words}, m_words);
    check("ld_ovf", {31'd0, ld_ovf}, {31'd0, m_ovf});
    check("req_ready_back", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int k = $urandom_range(0, 9);
    logic [31:0] r = $urandom;
    if (k == 0) return {20'd0, r[11:2], 2'b00} | 32'(($urandom_range(1, 3)));
    if (k == 1) return r | 32'h0000_1000;
    return {20'd0, r[11:2], 2'b00};
  endfunction

  initial begin
    int n;
    logic [31:0] saved0;
    rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_addr = '0;
    ld_en = 1'b0; ld_valid = 1'b0; ld_byte = '0;
    m_valid = 1'b0; m_err = 1'b0; m_data = '0; m_words = 0; m_ovf = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    check("rst_ld_words", {21'd0, ld_words}, 32'd0);
    check("rst_ld_ovf", {31'd0, ld_ovf}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two-instruction program and back-to-back fetches.
    src_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    load_run();
    check("plan_words", {21'd0, ld_words}, 32'd2);
    cyc(1'b1, 32'h0, 1'b1);
    check("plan_rsp0", rsp_data, 32'h0000_0013);
    cyc(1'b1, 32'h4, 1'b1);
    check("plan_rsp1", rsp_data, 32'h0010_0093);
    check("plan_rsp1_valid", {31'd0, rsp_valid}, 32'd1);
    cyc(1'b0, 32'h0, 1'b1);

    // Backpressure holds the slot.
    cyc(1'b1, 32'h4, 1'b0);
    repeat (3) cyc(1'b1, 32'h0, 1'b0);
    check("bp_hold", rsp_data, 32'h0010_0093);
    cyc(1'b1, 32'h0, 1'b1);
    check("bp_next", rsp_data, 32'h0000_0013);
    cyc(1'b0, 32'h0, 1'b1);

    // Misaligned and out-of-range fetches.
    cyc(1'b1, 32'h2, 1'b1);
    check("err_misalign", {31'd0, rsp_err}, 32'd1);
    cyc(1'b1, 32'h1000, 1'b1);
    check("err_range", {31'd0, rsp_err}, 32'd1);
    check("err_nop", rsp_data, NOP);
    cyc(1'b0, 32'h0, 1'b1);

    // Partial word flushed with zero upper lanes.
    src_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    load_run();
    cyc(1'b1, 32'h0, 1'b1);
    check("part_w0", rsp_data, 32'hDDCC_BBAA);
    cyc(1'b1, 32'h4, 1'b1);
    check("part_w1", rsp_data, 32'h0000_00EE);
    cyc(1'b0, 32'h0, 1'b1);

    // Overflow: one word more than the array holds.
    for (int i = 0; i < 4 * DEPTH + 4; i++) src_q.push_back(8'($urandom));
    load_run();
    check("ovf_flag", {31'd0, ld_ovf}, 32'd1);

    // Random fetch traffic over the now fully defined array.
    for (int i = 0; i < 3000; i++) cyc(1'($urandom), rand_addr(), 1'($urandom));
    cyc(1'b0, 32'h0, 1'b1);

    // Random short loads, read back word by word.
    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) src_q.push_back(8'($urandom));
      load_run();
      for (int i = 0; i < (n + 3) / 4 + 2; i++) cyc(1'b1, 32'(4 * i), 1'($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0, 1'b1);
    end

    // Reset drops a pending response.
    cyc(1'b1, 32'h8, 1'b0);
    req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_valid = 1'b0;
    check("rst_drop_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_drop_data", rsp_data, 32'd0);

    // Reset mid-load discards the partial word and leaves the array untouched.
    saved0 = m_mem[0];
    rsp_ready = 1'b1;
    ld_en = 1'b1;
    @(posedge clk);
    #1;
    ld_valid = 1'b1;
    ld_byte = ~saved0[7:0];
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ld_en = 1'b0;
    ld_valid = 1'b0;
    check("mid_rst_words", {21'd0, ld_words}, 32'd0);
    check("mid_rst_ovf", {31'd0, ld_ovf}, 32'd0);
    cyc(1'b1, 32'h0, 1'b1);
    check("mid_rst_mem0", rsp_data, saved0);
    cyc(1'b0, 32'h0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
